if_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage sitting between the pre-IF stage (request issue) and the decode stage. It replaces the single-slot fetch register and one-word instruction buffer with a DEPTH-entry in-order queue. The queue tracks up to DEPTH outstanding inst_sram requests, captures their returns, and delivers instructions to decode in program order. On flush it drops every response still in flight for squashed requests.

---
 rtl/if_fetch_queue_pkg.sv | 25 ++
 rtl/if_fetch_queue_if.sv | 41 ++++
 rtl/if_fetch_queue.sv | 158 +++++++++++++++
 tb/tb_if_fetch_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared defaults and types for the instruction-fetch queue.
// Widths here are the core defaults; the queue itself stays parametric.
package if_fetch_queue_pkg;

    localparam int IF_FQ_DEPTH = 4;
    localparam int FQ_PC_W     = 32;
    localparam int FQ_INST_W   = 32;
    localparam int FQ_EXC_W    = 5;

    // Width of the fetch-to-decode bus for a given field sizing.
    function automatic int fs_to_ds_bus_wd(input int pc_w, input int inst_w, input int exc_w);
        return pc_w * 2 + inst_w + exc_w + 2;
    endfunction

    // Field layout of the fetch-to-decode bus at default widths (MSB first).
    typedef struct packed {
        logic                 tlb_refill;
        logic [FQ_EXC_W-1:0]  excode;
        logic                 ex;
        logic [FQ_PC_W-1:0]   badvaddr;
        logic [FQ_INST_W-1:0] inst;
        logic [FQ_PC_W-1:0]   pc;
    } fs_to_ds_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue boundary: pre-IF request, inst_sram response, decode handoff, flush.
// master drives requests/responses/flush; slave is the queue.
interface if_fetch_queue_if
    import if_fetch_queue_pkg::*;
#(
    parameter int PC_W   = FQ_PC_W,
    parameter int INST_W = FQ_INST_W,
    parameter int EXC_W  = FQ_EXC_W
);
    localparam int BUS_W = fs_to_ds_bus_wd(PC_W, INST_W, EXC_W);

    logic              req_valid;
    logic              req_ready;
    logic [PC_W-1:0]   req_pc;
    logic              req_ex;
    logic [EXC_W-1:0]  req_excode;
    logic [PC_W-1:0]   req_badvaddr;
    logic              req_tlb_refill;
    logic              inst_sram_data_ok;
    logic [INST_W-1:0] inst_sram_rdata;
    logic              ds_allowin;
    logic              fs_to_ds_valid;
    logic [BUS_W-1:0]  fs_to_ds_bus;
    logic              fs_ex;
    logic              fs_inst_waiting;
    logic              fs_empty;
    logic              do_flush;

    modport master (
        output req_valid, req_pc, req_ex, req_excode, req_badvaddr, req_tlb_refill,
        output inst_sram_data_ok, inst_sram_rdata, ds_allowin, do_flush,
        input  req_ready, fs_to_ds_valid, fs_to_ds_bus, fs_ex, fs_inst_waiting, fs_empty
    );

    modport slave (
        input  req_valid, req_pc, req_ex, req_excode, req_badvaddr, req_tlb_refill,
        input  inst_sram_data_ok, inst_sram_rdata, ds_allowin, do_flush,
        output req_ready, fs_to_ds_valid, fs_to_ds_bus, fs_ex, fs_inst_waiting, fs_empty
    );

endinterface

// File: rtl/if_fetch_queue.sv
// In-order DEPTH-entry fetch queue: data_ok in N -> decode-valid in N+1, no rdata bypass.
// req_ready drops when full or when outstanding sram requests (live + discarded) reach DEPTH.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH  = IF_FQ_DEPTH,
    parameter int PC_W   = FQ_PC_W,
    parameter int INST_W = FQ_INST_W,
    parameter int EXC_W  = FQ_EXC_W
) (
    input  logic            clk,
    input  logic            reset,
    if_fetch_queue_if.slave fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   FULL_OUT = (CNT_W + 1)'(DEPTH);

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [DEPTH-1:0]  ent_ex;
    logic [DEPTH-1:0]  ent_refill;
    logic [EXC_W-1:0]  ent_excode [DEPTH];
    logic [PC_W-1:0]   ent_badvaddr [DEPTH];
    logic [PC_W-1:0]   ent_pc [DEPTH];
    logic [INST_W-1:0] ent_inst [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fill;
    logic [PTR_W-1:0] tail_nxt;
    logic [PTR_W-1:0] fill_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] discard_cnt;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] flush_discard;
    logic [CNT_W:0]   outstanding;

    logic alloc;
    logic pop;
    logic head_out;
    logic fill_pend;
    logic dok_fill;
    logic dok_discard;
    logic skip_ex;
    logic [INST_W-1:0] head_inst;

    // Live entries still waiting for their sram response.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending + CNT_W'(ent_valid[i] & ~ent_done[i]);
        end
    end

    // Every request the sram still owes us, whether it will be kept or dropped.
    assign outstanding = {1'b0, pending} + {1'b0, discard_cnt};

    assign fq.req_ready = (count < FULL) && (outstanding < FULL_OUT) && !fq.do_flush;
    assign alloc        = fq.req_valid && fq.req_ready;
    assign head_out     = ent_valid[head] && ent_done[head] && !fq.do_flush;
    assign pop          = head_out && fq.ds_allowin;
    assign fill_pend    = ent_valid[fill] && !ent_done[fill];
    assign dok_discard  = fq.inst_sram_data_ok && (discard_cnt != '0);
    assign dok_fill     = fq.inst_sram_data_ok && (discard_cnt == '0) && fill_pend;

    // A response landing in the flush cycle retires one of the owed requests.
    always_comb begin
        flush_discard = '0;
        if (outstanding != '0) begin
            flush_discard = CNT_W'(outstanding - {{CNT_W{1'b0}}, fq.inst_sram_data_ok});
        end
    end

    // Fill stops only on a non-ex entry; ex entries get no response and are stepped over,
    // including one being allocated this cycle.
    always_comb begin
        tail_nxt = alloc ? tail + PTR_W'(1) : tail;
        fill_nxt = dok_fill ? fill + PTR_W'(1) : fill;
        skip_ex  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fill_nxt != tail_nxt) begin
                skip_ex = (alloc && fill_nxt == tail) ? fq.req_ex : ent_ex[fill_nxt];
                if (skip_ex) begin
                    fill_nxt = fill_nxt + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            count       <= '0;
            discard_cnt <= '0;
            ent_valid   <= '0;
            ent_done    <= '0;
            ent_ex      <= '0;
            ent_refill  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_excode[i]   <= '0;
                ent_badvaddr[i] <= '0;
                ent_pc[i]       <= '0;
                ent_inst[i]     <= '0;
            end
        end else if (fq.do_flush) begin
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            count       <= '0;
            discard_cnt <= flush_discard;
            ent_valid   <= '0;
        end else begin
            if (alloc) begin
                ent_valid[tail]    <= 1'b1;
                ent_done[tail]     <= fq.req_ex;
                ent_ex[tail]       <= fq.req_ex;
                ent_refill[tail]   <= fq.req_tlb_refill;
                ent_excode[tail]   <= fq.req_excode;
                ent_badvaddr[tail] <= fq.req_badvaddr;
                ent_pc[tail]       <= fq.req_pc;
                ent_inst[tail]     <= '0;
            end
            if (dok_fill) begin
                ent_inst[fill] <= fq.inst_sram_rdata;
                ent_done[fill] <= 1'b1;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
            end
            if (dok_discard) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
            head  <= head + PTR_W'(pop);
            tail  <= tail_nxt;
            fill  <= fill_nxt;
            count <= count + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    assign head_inst          = ent_ex[head] ? '0 : ent_inst[head];
    assign fq.fs_to_ds_valid  = head_out;
    assign fq.fs_to_ds_bus    = {ent_refill[head], ent_excode[head], ent_ex[head],
                                 ent_badvaddr[head], head_inst, ent_pc[head]};
    assign fq.fs_ex           = ent_valid[head] && ent_ex[head];
    assign fq.fs_inst_waiting = (pending != '0);
    assign fq.fs_empty        = (count == '0);

    // A response must belong either to a squashed request or to the oldest live one.
    a_no_orphan_data: assert property (
        @(posedge clk) disable iff (reset)
        fq.inst_sram_data_ok |-> (discard_cnt != '0 || fill_pend)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboarded bench for if_fetch_queue: directed scenarios then random traffic
// against a transaction-level model (expected deliveries + sram response tokens).
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam int DEPTH = IF_FQ_DEPTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    if_fetch_queue_if fq ();

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] badvaddr;
        logic        refill;
        logic [31:0] inst;
        bit          done;
    } exp_t;

    // One token per sram request issued; live == its data will be kept.
    typedef struct {
        int          id;
        bit          live;
        logic [31:0] data;
    } tok_t;

    exp_t exp_q[$];
    tok_t tok_q[$];
    int   total = 0;
    int   bad = 0;
    int   next_id = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        fq.req_valid         = 1'b0;
        fq.req_pc            = '0;
        fq.req_ex            = 1'b0;
        fq.req_excode        = '0;
        fq.req_badvaddr      = '0;
        fq.req_tlb_refill    = 1'b0;
        fq.inst_sram_data_ok = 1'b0;
        fq.inst_sram_rdata   = '0;
        fq.ds_allowin        = 1'b0;
        fq.do_flush          = 1'b0;
    endtask

    function automatic int live_tokens();
        int n = 0;
        foreach (tok_q[i]) if (tok_q[i].live) n++;
        return n;
    endfunction

    // One clock of stimulus; rd is the data the sram will later return for this request.
    task automatic cycle(input bit rv, input logic [31:0] pc, input bit ex, input logic [4:0] exc,
                         input logic [31:0] bv, input bit rf, input logic [31:0] rd,
                         input bit dok, input bit allow, input bit fl);
        bit   dok_eff;
        bit   rdy_exp;
        tok_t t;
        exp_t e;
        @(posedge clk);
        #1;
        dok_eff = dok && (tok_q.size() > 0);
        fq.req_valid         = rv;
        fq.req_pc            = pc;
        fq.req_ex            = ex;
        fq.req_excode        = exc;
        fq.req_badvaddr      = bv;
        fq.req_tlb_refill    = rf;
        fq.inst_sram_data_ok = dok_eff;
        if (dok_eff) fq.inst_sram_rdata = tok_q[0].data;
        else         fq.inst_sram_rdata = $urandom;
        fq.ds_allowin        = allow;
        fq.do_flush          = fl;
        #1;
        rdy_exp = (exp_q.size() < DEPTH) && (tok_q.size() < DEPTH) && !fl;
        chk("req_ready", fq.req_ready, rdy_exp);
        chk("fs_to_ds_valid", fq.fs_to_ds_valid, (exp_q.size() > 0) && exp_q[0].done && !fl);
        chk("fs_ex", fq.fs_ex, (exp_q.size() > 0) && exp_q[0].ex);
        chk("fs_empty", fq.fs_empty, exp_q.size() == 0);
        chk("fs_inst_waiting", fq.fs_inst_waiting, live_tokens() > 0);
        @(negedge clk);
        if (dok_eff) begin
            t = tok_q.pop_front();
            if (t.live && !fl) begin
                foreach (exp_q[i]) if (exp_q[i].id == t.id) exp_q[i].done = 1'b1;
            end
        end
        if (fl) begin
            foreach (tok_q[i]) tok_q[i].live = 1'b0;
            exp_q.delete();
        end else if (rv && rdy_exp) begin
            e = '{id: next_id, pc: pc, ex: ex, excode: exc, badvaddr: bv, refill: rf,
                  inst: ex ? 32'h0 : rd, done: ex};
            exp_q.push_back(e);
            if (!ex) tok_q.push_back('{id: next_id, live: 1'b1, data: rd});
            next_id++;
        end
    endtask

    task automatic idle(input bit dok, input bit allow);
        cycle(1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0, dok, allow, 1'b0);
    endtask

    task automatic req(input logic [31:0] pc, input logic [31:0] rd, input bit dok, input bit allow);
        cycle(1'b1, pc, 1'b0, 5'h0, 32'h0, 1'b0, rd, dok, allow, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || tok_q.size() > 0) && n < 60) begin
            idle(1'b1, 1'b1);
            n++;
        end
        total++;
        if (exp_q.size() > 0 || tok_q.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout entries=%0d responses=%0d required 0 and 0",
                     exp_q.size(), tok_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        tok_q.delete();
        #1;
        chk("rst_req_ready", fq.req_ready, 1'b1);
        chk("rst_fs_to_ds_valid", fq.fs_to_ds_valid, 1'b0);
        chk("rst_fs_ex", fq.fs_ex, 1'b0);
        chk("rst_fs_inst_waiting", fq.fs_inst_waiting, 1'b0);
        chk("rst_fs_empty", fq.fs_empty, 1'b1);
        chk("rst_fs_to_ds_bus", fq.fs_to_ds_bus, '0);
    endtask

    // Monitor: every decode handshake pops and checks the oldest expected delivery.
    always @(negedge clk) begin : monitor
        exp_t      e;
        fs_to_ds_t b;
        if (reset === 1'b0 && fq.fs_to_ds_valid === 1'b1 && fq.ds_allowin === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_delivery bus=%0h required no delivery", fq.fs_to_ds_bus);
            end else begin
                e = exp_q.pop_front();
                b.tlb_refill = e.refill;
                b.excode     = e.excode;
                b.ex         = e.ex;
                b.badvaddr   = e.badvaddr;
                b.inst       = e.ex ? 32'h0 : e.inst;
                b.pc         = e.pc;
                chk("fs_to_ds_bus", fq.fs_to_ds_bus, b);
            end
        end
    end

    initial begin
        drive_idle();
        do_reset();

        // Single fetch, response two cycles after issue.
        req(32'hBFC0_0000, 32'h3C1D_0001, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        drain();

        // Back-to-back issue with one response per cycle.
        for (int i = 0; i < 4; i++) req(32'h0000_1000 + 32'(i * 4), $urandom, 1'b1, 1'b1);
        drain();

        // Fill to DEPTH with decode stalled, then release.
        for (int i = 0; i < 4; i++) req(32'h0000_2000 + 32'(i * 4), $urandom, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        drain();

        // Faulted fetch between two normal ones.
        req(32'h0000_3000, 32'h1111_2222, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_3004, 1'b1, 5'd4, 32'h0000_0003, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        req(32'h0000_3008, 32'h3333_4444, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        drain();

        // Flush with three responses outstanding, then a new fetch.
        for (int i = 0; i < 3; i++) req(32'h0000_4000 + 32'(i * 4), $urandom, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        req(32'h8000_0180, 32'h4200_0018, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
        drain();

        // Flush coinciding with a response while two are pending.
        for (int i = 0; i < 2; i++) req(32'h0000_5000 + 32'(i * 4), $urandom, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        req(32'h8000_0200, 32'h0123_4567, 1'b1, 1'b1);
        drain();

        // Reset in the middle of traffic.
        req(32'h0000_6000, $urandom, 1'b0, 1'b0);
        req(32'h0000_6004, $urandom, 1'b1, 1'b0);
        do_reset();

        for (int c = 0; c < 800; c++) begin
            cycle($urandom_range(3) != 0, $urandom & 32'hFFFF_FFFC, $urandom_range(7) == 0,
                  5'($urandom), $urandom, 1'($urandom), $urandom,
                  $urandom_range(2) != 0, $urandom_range(3) != 0, $urandom_range(39) == 0);
        end
        drain();
        idle(1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
